// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the byte-sliced multiword adder sequencer.
package multiword_add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width; a single-slice build still needs a 1-bit counter.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared 8-bit ripple-carry adder: {CARRY_OUT, SUM} = A + B + CARRY_IN.
module adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CARRY_IN,
  output logic [7:0] SUM,
  output logic       CARRY_OUT
);

  logic w_c;

  always_comb begin
    w_c = CARRY_IN;
    SUM = '0;
    for (int i = 0; i < 8; i++) begin
      SUM[i] = A[i] ^ B[i] ^ w_c;
      w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
    end
    CARRY_OUT = w_c;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds WORDS-byte operands by running one shared 8-bit adder over the slices,
// least-significant first, chaining the carry through a register.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START_VALID,
  output logic                     START_READY,
  input  logic [SLICE_W*WORDS-1:0] A,
  input  logic [SLICE_W*WORDS-1:0] B,
  input  logic                     CARRY_IN,
  output logic                     RESULT_VALID,
  input  logic                     RESULT_READY,
  output logic [SLICE_W*WORDS-1:0] SUM,
  output logic                     CARRY_OUT,
  output logic                     BUSY,
  output state_t                   DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a held result stays stable.

  localparam int                IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t                          r_state;
  state_t                          w_next_state;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_carry;
  logic                            r_cout;
  logic [WORDS-1:0][SLICE_W-1:0]   r_a;
  logic [WORDS-1:0][SLICE_W-1:0]   r_b;
  logic [WORDS-1:0][SLICE_W-1:0]   r_sum;

  logic [SLICE_W-1:0]              w_slice_a;
  logic [SLICE_W-1:0]              w_slice_b;
  logic [SLICE_W-1:0]              w_slice_sum;
  logic                            w_slice_cout;
  logic                            w_last;

  assign w_slice_a = r_a[r_idx];
  assign w_slice_b = r_b[r_idx];
  assign w_last    = (r_idx == LAST_IDX);

  adder u_adder (w_slice_a, w_slice_b, r_carry, w_slice_sum, w_slice_cout);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    START_READY  = 1'b0;
    RESULT_VALID = 1'b0;
    BUSY         = 1'b0;
    case (r_state)
      IDLE: begin
        START_READY = 1'b1;
        if (START_VALID) w_next_state = RUN;
      end
      RUN: begin
        BUSY = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        BUSY         = 1'b1;
        RESULT_VALID = 1'b1;
        if (RESULT_READY) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Untouched upper SUM slices keep the previous result until overwritten.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START_VALID) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CARRY_IN;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx] <= w_slice_sum;
          r_carry      <= w_slice_cout;
          if (w_last) begin
            r_cout <= w_slice_cout;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SUM       = r_sum;
  assign CARRY_OUT = r_cout;
  assign DBG_STATE = r_state;

endmodule
